ace_snoop_initiator: RTL and testbench
======================================

# ace_snoop_initiator

Interconnect-side snoop master for ACE4 coherency, driving the AC snoop channel and collecting the CR response and CD data channels of one cached master. It sits between the home-node request queue and each CPU cluster's snoop port. It issues one snoop at a time, tracks response and data completion independently, and applies a timeout. It returns a merged result, including line data when supplied, to the requester.

## Interface
Parameters:
- ADDR_W, 48, snoop address width
- DATA_W, 512, CD data width; one beat carries one full cache line
- ID_W, 6, requester tag width, returned unchanged
- TIMEOUT, 1024, cycles allowed from AC handshake to completion; range 2..65535

Ports (clock and reset first):
- clk  in  1  single clock domain
- rst_n  in  1  active-low reset, asserted asynchronously, deasserted synchronously to clk
- req_valid / req_ready  in / out  1 / 1  request handshake from home node
- req_addr  in  ADDR_W  line address; bits [5:0] ignored and driven as 0 on AC
- req_snoop  in  4  ACE AC snoop opcode
- req_prot  in  3  AC protection
- req_id  in  ID_W  requester tag
- ace_acvalid / ace_acready  out / in  1 / 1  AC handshake
- ace_acaddr  out  ADDR_W  snoop address
- ace_acsnoop  out  4  snoop opcode
- ace_acprot  out  3  protection
- ace_crvalid / ace_crready  in / out  1 / 1  CR handshake
- ace_crresp  in  5  {WasUnique, IsShared, PassDirty, Error, DataTransfer}, bit 0 = DataTransfer
- ace_cdvalid / ace_cdready  in / out  1 / 1  CD handshake
- ace_cddata  in  DATA_W  snoop data
- ace_cdlast  in  1  last CD beat
- rsp_valid / rsp_ready  out / in  1 / 1  result handshake to home node
- rsp_id  out  ID_W  tag of the completed request
- rsp_crresp  out  5  captured CR value; 0 on timeout
- rsp_has_data  out  1  rsp_data is valid
- rsp_data  out  DATA_W  captured CD beat
- rsp_timeout  out  1  completion was forced by timeout
- proto_err  out  1  sticky; set on a CD/CR mismatch; cleared only by reset
- snoop_count  out  32  snoops issued, counted on the AC handshake, wraps
- timeout_count  out  32  timeouts, wraps
- init_fsm_state  out  2  current state encoding

## Operation
- States:
  - IDLE=0: req_ready=1. On req_valid, latch addr/snoop/prot/id, clear the completion flags, go to ISSUE.
  - ISSUE=1: ace_acvalid=1. On ace_acready, increment snoop_count, load the timer with TIMEOUT, go to WAIT.
  - WAIT=2: ace_crready = !cr_done. ace_cdready = !cd_done. The timer decrements each cycle.
  - RESP=3: rsp_valid=1. On rsp_ready, go to IDLE.
- CR handshake: capture crresp, set cr_done.
- CD handshake: capture cddata, set cd_done. A beat with cdlast=0 also sets cd_done and sets proto_err.
- CD may complete before, with, or after CR. Both in the same cycle are accepted together.
- WAIT exits to RESP when cr_done is set and either DataTransfer=0 or cd_done is set.
- CD received but the captured CR has DataTransfer=0: set proto_err, rsp_has_data=0, complete normally.
- Timeout: timer reaches 0 in WAIT before completion. Go to RESP with rsp_timeout=1, rsp_crresp = captured value or 0, rsp_has_data=cd_done. Increment timeout_count.
- Timeout in the same cycle as the completing handshake: completion wins, no timeout.
- rsp_has_data = cd_done & DataTransfer on a normal completion.
- Counters wrap from 0xFFFFFFFF to 0 with no saturation.

## Timing
- Reset values: all valid/ready outputs 0 except req_ready=1 (IDLE). Data/address outputs 0. proto_err 0. Counters 0. State IDLE.
- Reset asserted mid-operation abandons the snoop; no response is generated.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Minimum latency from req handshake to rsp_valid is 3 cycles (ISSUE 1, WAIT ≥1, RESP), given acready and crvalid high and no data.
- AC outputs stay stable while acvalid=1 and acready=0. rsp_* stay stable while rsp_valid=1 and rsp_ready=0.
- A new request is accepted no earlier than the cycle after the rsp handshake.

## Structure
- Shared package ace_snoop_pkg:
  - state enum
  - AC opcode localparams (ReadOnce=0x0, ReadShared=0x1, ReadClean=0x2, ReadNotSharedDirty=0x3, ReadUnique=0x7, CleanShared=0x8, CleanInvalid=0x9, MakeInvalid=0xD, DVM Complete=0xE, DVM Message=0xF)
  - CR bit-index constants
- One natural sub-module: snoop_timeout_timer, a loadable down-counter with an expire pulse.

## Test plan
- ReadShared addr 0x1000_0040: acready=1, CR=0x08 one cycle later, no CD -> rsp_valid, rsp_crresp=0x08, rsp_has_data=0, snoop_count=1.
- ReadUnique: CD beat 0xA5.. with cdlast=1 arrives 2 cycles before CR=0x05 -> rsp_has_data=1, rsp_data=0xA5.., rsp_crresp=0x05, proto_err=0.
- TIMEOUT=8: acready=1, crvalid never asserted -> rsp_timeout=1 exactly 8 cycles after the AC handshake, rsp_crresp=0, timeout_count=1.
- CR=0x00 and a CD beat accepted in the same cycle -> proto_err=1, rsp_has_data=0, proto_err remains 1 after the next transaction.
- acready and rsp_ready held low 5 cycles each -> AC fields and rsp fields stable throughout, req_ready=0 until the rsp handshake.
- rst_n asserted during WAIT -> next cycle state IDLE, acvalid/crready/cdready/rsp_valid=0, req_ready=1, counters 0.

Source files
------------

// File: rtl/ace_snoop_initiator_pkg.sv
// Shared types and constants for the ACE snoop initiator: FSM states, AC snoop
// opcodes and CR response bit positions.
package ace_snoop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [3:0] AC_READ_ONCE              = 4'h0;
  localparam logic [3:0] AC_READ_SHARED            = 4'h1;
  localparam logic [3:0] AC_READ_CLEAN             = 4'h2;
  localparam logic [3:0] AC_READ_NOT_SHARED_DIRTY  = 4'h3;
  localparam logic [3:0] AC_READ_UNIQUE            = 4'h7;
  localparam logic [3:0] AC_CLEAN_SHARED           = 4'h8;
  localparam logic [3:0] AC_CLEAN_INVALID          = 4'h9;
  localparam logic [3:0] AC_MAKE_INVALID           = 4'hD;
  localparam logic [3:0] AC_DVM_COMPLETE           = 4'hE;
  localparam logic [3:0] AC_DVM_MESSAGE            = 4'hF;

  localparam int unsigned CR_DATA_TRANSFER = 0;
  localparam int unsigned CR_ERROR         = 1;
  localparam int unsigned CR_PASS_DIRTY    = 2;
  localparam int unsigned CR_IS_SHARED     = 3;
  localparam int unsigned CR_WAS_UNIQUE    = 4;

  function automatic logic cr_has_data(input logic [4:0] crresp);
    return crresp[CR_DATA_TRANSFER];
  endfunction

endpackage

// File: rtl/ace_snoop_initiator_timer.sv
// Loadable down-counter; expire_o pulses in the enabled cycle that takes the
// count from 1 to 0.
module snoop_timeout_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (en_i && (count_q != '0))
      count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign expire_o = en_i && (count_q == CNT_W'(1));

endmodule

// File: rtl/ace_snoop_initiator.sv
// ACE snoop master: issues one AC snoop at a time, collects CR/CD independently,
// applies a timeout and returns a merged result to the home node.
module ace_snoop_initiator
  import ace_snoop_pkg::*;
#(
  parameter int unsigned ADDR_W  = 48,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned ID_W    = 6,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_snoop,
  input  logic [2:0]        req_prot,
  input  logic [ID_W-1:0]   req_id,
  output logic              ace_acvalid,
  input  logic              ace_acready,
  output logic [ADDR_W-1:0] ace_acaddr,
  output logic [3:0]        ace_acsnoop,
  output logic [2:0]        ace_acprot,
  input  logic              ace_crvalid,
  output logic              ace_crready,
  input  logic [4:0]        ace_crresp,
  input  logic              ace_cdvalid,
  output logic              ace_cdready,
  input  logic [DATA_W-1:0] ace_cddata,
  input  logic              ace_cdlast,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [4:0]        rsp_crresp,
  output logic              rsp_has_data,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              proto_err,
  output logic [31:0]       snoop_count,
  output logic [31:0]       timeout_count,
  output logic [1:0]        init_fsm_state
);

  localparam int unsigned TIMER_W = 16;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(63);

  state_e            state_q;
  logic [ADDR_W-1:0] acaddr_q;
  logic [3:0]        acsnoop_q;
  logic [2:0]        acprot_q;
  logic [ID_W-1:0]   id_q;
  logic              cr_done_q, cd_done_q;
  logic [4:0]        crresp_q;
  logic [DATA_W-1:0] cddata_q;
  logic              has_data_q, timeout_q, proto_err_q;
  logic [31:0]       snoop_cnt_q, timeout_cnt_q;

  logic              cr_hs, cd_hs, cr_done_d, cd_done_d, complete, expire;
  logic [4:0]        crresp_d;

  // Completion looks at this cycle's handshakes so a same-cycle finish beats the timer.
  always_comb begin
    cr_hs     = (state_q == ST_WAIT) && !cr_done_q && ace_crvalid;
    cd_hs     = (state_q == ST_WAIT) && !cd_done_q && ace_cdvalid;
    cr_done_d = cr_done_q | cr_hs;
    cd_done_d = cd_done_q | cd_hs;
    crresp_d  = cr_hs ? ace_crresp : crresp_q;
    complete  = cr_done_d && (!cr_has_data(crresp_d) || cd_done_d);
  end

  snoop_timeout_timer #(.CNT_W(TIMER_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    ((state_q == ST_ISSUE) && ace_acready),
    .load_val_i(TIMER_W'(TIMEOUT)),
    .en_i      (state_q == ST_WAIT),
    .expire_o  (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      acaddr_q      <= '0;
      acsnoop_q     <= '0;
      acprot_q      <= '0;
      id_q          <= '0;
      cr_done_q     <= 1'b0;
      cd_done_q     <= 1'b0;
      crresp_q      <= '0;
      cddata_q      <= '0;
      has_data_q    <= 1'b0;
      timeout_q     <= 1'b0;
      proto_err_q   <= 1'b0;
      snoop_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid) begin
          acaddr_q   <= req_addr & LINE_MASK;
          acsnoop_q  <= req_snoop;
          acprot_q   <= req_prot;
          id_q       <= req_id;
          cr_done_q  <= 1'b0;
          cd_done_q  <= 1'b0;
          crresp_q   <= '0;
          has_data_q <= 1'b0;
          timeout_q  <= 1'b0;
          state_q    <= ST_ISSUE;
        end
        ST_ISSUE: if (ace_acready) begin
          snoop_cnt_q <= snoop_cnt_q + 32'd1;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          cr_done_q <= cr_done_d;
          cd_done_q <= cd_done_d;
          crresp_q  <= crresp_d;
          if (cd_hs) cddata_q <= ace_cddata;
          if ((cd_hs && !ace_cdlast) || (complete && cd_done_d && !cr_has_data(crresp_d)))
            proto_err_q <= 1'b1;
          if (complete) begin
            has_data_q <= cd_done_d && cr_has_data(crresp_d);
            timeout_q  <= 1'b0;
            state_q    <= ST_RESP;
          end else if (expire) begin
            has_data_q    <= cd_done_d;
            timeout_q     <= 1'b1;
            timeout_cnt_q <= timeout_cnt_q + 32'd1;
            state_q       <= ST_RESP;
          end
        end
        ST_RESP: if (rsp_ready) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign ace_acvalid    = (state_q == ST_ISSUE);
  assign ace_acaddr     = acaddr_q;
  assign ace_acsnoop    = acsnoop_q;
  assign ace_acprot     = acprot_q;
  assign ace_crready    = (state_q == ST_WAIT) && !cr_done_q;
  assign ace_cdready    = (state_q == ST_WAIT) && !cd_done_q;
  assign rsp_valid      = (state_q == ST_RESP);
  assign rsp_id         = id_q;
  assign rsp_crresp     = crresp_q;
  assign rsp_has_data   = has_data_q;
  assign rsp_data       = cddata_q;
  assign rsp_timeout    = timeout_q;
  assign proto_err      = proto_err_q;
  assign snoop_count    = snoop_cnt_q;
  assign timeout_count  = timeout_cnt_q;
  assign init_fsm_state = state_q;

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Directed bench for ace_snoop_initiator with an expected-response scoreboard.
module tb_ace_snoop_initiator;

  localparam int unsigned ADDR_W = 48;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned ID_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_snoop;
  logic [2:0]        req_prot;
  logic [ID_W-1:0]   req_id;
  logic              ace_acvalid, ace_acready;
  logic [ADDR_W-1:0] ace_acaddr;
  logic [3:0]        ace_acsnoop;
  logic [2:0]        ace_acprot;
  logic              ace_crvalid, ace_crready;
  logic [4:0]        ace_crresp;
  logic              ace_cdvalid, ace_cdready;
  logic [DATA_W-1:0] ace_cddata;
  logic              ace_cdlast;
  logic              rsp_valid, rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [4:0]        rsp_crresp;
  logic              rsp_has_data;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_timeout;
  logic              proto_err;
  logic [31:0]       snoop_count, timeout_count;
  logic [1:0]        init_fsm_state;

  ace_snoop_initiator #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_snoop(req_snoop), .req_prot(req_prot), .req_id(req_id),
    .ace_acvalid(ace_acvalid), .ace_acready(ace_acready), .ace_acaddr(ace_acaddr),
    .ace_acsnoop(ace_acsnoop), .ace_acprot(ace_acprot),
    .ace_crvalid(ace_crvalid), .ace_crready(ace_crready), .ace_crresp(ace_crresp),
    .ace_cdvalid(ace_cdvalid), .ace_cdready(ace_cdready), .ace_cddata(ace_cddata),
    .ace_cdlast(ace_cdlast),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_crresp(rsp_crresp), .rsp_has_data(rsp_has_data), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .proto_err(proto_err),
    .snoop_count(snoop_count), .timeout_count(timeout_count),
    .init_fsm_state(init_fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [4:0]        crresp;
    logic              has_data;
    logic [DATA_W-1:0] data;
    logic              timeout;
  } exp_t;

  exp_t exp_q[$];
  int unsigned npass  = 0;
  int unsigned ntotal = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [ID_W-1:0] id, input logic [4:0] cr,
                          input logic hd, input logic [DATA_W-1:0] d, input logic to);
    exp_t e;
    e.id = id; e.crresp = cr; e.has_data = hd; e.data = d; e.timeout = to;
    exp_q.push_back(e);
  endtask

  task automatic drive_req(input logic [ADDR_W-1:0] a, input logic [3:0] sn,
                           input logic [2:0] pr, input logic [ID_W-1:0] id);
    req_addr = a; req_snoop = sn; req_prot = pr; req_id = id; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 40 && !rsp_valid; i++) step();
    chk({tag, "_rsp_valid"}, 512'(rsp_valid), 512'(1));
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 512'(0), 512'(1));
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_id"},       512'(rsp_id),       512'(e.id));
      chk({tag, "_crresp"},   512'(rsp_crresp),   512'(e.crresp));
      chk({tag, "_has_data"}, 512'(rsp_has_data), 512'(e.has_data));
      chk({tag, "_timeout"},  512'(rsp_timeout),  512'(e.timeout));
      if (e.has_data) chk({tag, "_data"}, 512'(rsp_data), 512'(e.data));
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] a5;
    a5 = {64{8'hA5}};
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_snoop = '0; req_prot = '0;
    req_id = '0; ace_acready = 1'b1; ace_crvalid = 1'b0; ace_crresp = '0;
    ace_cdvalid = 1'b0; ace_cddata = '0; ace_cdlast = 1'b0; rsp_ready = 1'b0;
    step(); step();
    chk("rst_req_ready", 512'(req_ready),      512'(1));
    chk("rst_acvalid",   512'(ace_acvalid),    512'(0));
    chk("rst_crready",   512'(ace_crready),    512'(0));
    chk("rst_cdready",   512'(ace_cdready),    512'(0));
    chk("rst_rsp_valid", 512'(rsp_valid),      512'(0));
    chk("rst_acaddr",    512'(ace_acaddr),     512'(0));
    chk("rst_proto_err", 512'(proto_err),      512'(0));
    chk("rst_snoop_cnt", 512'(snoop_count),    512'(0));
    chk("rst_to_cnt",    512'(timeout_count),  512'(0));
    chk("rst_state",     512'(init_fsm_state), 512'(0));
    rst_n = 1'b1;
    step();

    // ReadShared, CR=0x08 one cycle after the AC handshake, minimum latency
    push_exp(6'd1, 5'h08, 1'b0, '0, 1'b0);
    drive_req(48'h1000_0040, 4'h1, 3'd2, 6'd1);
    chk("t1_acvalid",   512'(ace_acvalid), 512'(1));
    chk("t1_acaddr",    512'(ace_acaddr),  512'(48'h1000_0040));
    chk("t1_acsnoop",   512'(ace_acsnoop), 512'(4'h1));
    chk("t1_req_ready", 512'(req_ready),   512'(0));
    step();
    chk("t1_state_wait", 512'(init_fsm_state), 512'(2));
    chk("t1_snoop_cnt",  512'(snoop_count),    512'(1));
    chk("t1_crready",    512'(ace_crready),    512'(1));
    ace_crvalid = 1'b1; ace_crresp = 5'h08;
    step();
    ace_crvalid = 1'b0;
    chk("t1_min_latency", 512'(rsp_valid), 512'(1));
    pop_check("t1");
    finish_rsp();
    chk("t1_back_idle", 512'(req_ready), 512'(1));

    // ReadUnique, CD beat two cycles before CR=0x05; address low bits masked
    push_exp(6'd2, 5'h05, 1'b1, a5, 1'b0);
    drive_req(48'h2000_00BF, 4'h7, 3'd0, 6'd2);
    chk("t2_acaddr_mask", 512'(ace_acaddr), 512'(48'h2000_0080));
    step();
    ace_cdvalid = 1'b1; ace_cddata = a5; ace_cdlast = 1'b1;
    step();
    ace_cdvalid = 1'b0; ace_cddata = '0;
    chk("t2_cdready_done", 512'(ace_cdready), 512'(0));
    chk("t2_still_wait",   512'(rsp_valid),   512'(0));
    step();
    ace_crvalid = 1'b1; ace_crresp = 5'h05;
    step();
    ace_crvalid = 1'b0;
    wait_rsp("t2");
    pop_check("t2");
    chk("t2_proto_err", 512'(proto_err), 512'(0));
    finish_rsp();

    // No CR at all: forced completion exactly 8 cycles after the AC handshake
    push_exp(6'd3, 5'h00, 1'b0, '0, 1'b1);
    drive_req(48'h3000_0000, 4'h2, 3'd1, 6'd3);
    step();
    for (int i = 0; i < 7; i++) step();
    chk("t3_no_rsp_before_8", 512'(rsp_valid), 512'(0));
    step();
    chk("t3_rsp_at_8", 512'(rsp_valid), 512'(1));
    pop_check("t3");
    chk("t3_to_cnt", 512'(timeout_count), 512'(1));
    finish_rsp();

    // CR=0x00 with a CD beat in the same cycle: protocol error, no data returned
    push_exp(6'd4, 5'h00, 1'b0, '0, 1'b0);
    drive_req(48'h3100_0000, 4'h0, 3'd0, 6'd4);
    step();
    ace_crvalid = 1'b1; ace_crresp = 5'h00;
    ace_cdvalid = 1'b1; ace_cddata = 512'hDEAD_BEEF; ace_cdlast = 1'b1;
    step();
    ace_crvalid = 1'b0; ace_cdvalid = 1'b0;
    chk("t4_rsp_valid", 512'(rsp_valid), 512'(1));
    pop_check("t4");
    chk("t4_proto_err", 512'(proto_err), 512'(1));
    finish_rsp();

    // acready and rsp_ready stalled 5 cycles each
    push_exp(6'd5, 5'h0C, 1'b0, '0, 1'b0);
    ace_acready = 1'b0;
    drive_req(48'h4000_00C7, 4'h8, 3'd5, 6'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t5_acvalid_hold", 512'(ace_acvalid), 512'(1));
      chk("t5_acaddr_hold",  512'(ace_acaddr),  512'(48'h4000_00C0));
      chk("t5_acsnoop_hold", 512'(ace_acsnoop), 512'(4'h8));
      chk("t5_acprot_hold",  512'(ace_acprot),  512'(3'd5));
      chk("t5_req_ready_lo", 512'(req_ready),   512'(0));
      step();
    end
    ace_acready = 1'b1;
    step();
    ace_crvalid = 1'b1; ace_crresp = 5'h0C;
    step();
    ace_crvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_rsp_valid_hold", 512'(rsp_valid),  512'(1));
      chk("t5_rsp_id_hold",    512'(rsp_id),     512'(5));
      chk("t5_rsp_cr_hold",    512'(rsp_crresp), 512'(5'h0C));
      chk("t5_req_ready_lo2",  512'(req_ready),  512'(0));
      step();
    end
    pop_check("t5");
    finish_rsp();
    chk("t5_req_ready", 512'(req_ready),     512'(1));
    chk("t5_proto_sticky", 512'(proto_err),  512'(1));
    chk("t5_snoop_cnt", 512'(snoop_count),   512'(5));
    chk("t5_to_cnt",    512'(timeout_count), 512'(1));

    // Reset during WAIT abandons the snoop
    drive_req(48'h5000_0000, 4'h3, 3'd0, 6'd6);
    step();
    chk("t6_in_wait", 512'(init_fsm_state), 512'(2));
    rst_n = 1'b0;
    step();
    chk("t6_state",     512'(init_fsm_state), 512'(0));
    chk("t6_acvalid",   512'(ace_acvalid),    512'(0));
    chk("t6_crready",   512'(ace_crready),    512'(0));
    chk("t6_cdready",   512'(ace_cdready),    512'(0));
    chk("t6_rsp_valid", 512'(rsp_valid),      512'(0));
    chk("t6_req_ready", 512'(req_ready),      512'(1));
    chk("t6_snoop_cnt", 512'(snoop_count),    512'(0));
    chk("t6_to_cnt",    512'(timeout_count),  512'(0));
    chk("t6_proto_err", 512'(proto_err),      512'(0));
    rst_n = 1'b1;
    step(); step();
    chk("t6_no_rsp", 512'(rsp_valid), 512'(0));

    // CR with DataTransfer=1 but CD never arrives: timeout keeps captured CR
    push_exp(6'd7, 5'h01, 1'b0, '0, 1'b1);
    drive_req(48'h6000_0000, 4'h1, 3'd0, 6'd7);
    step();
    ace_crvalid = 1'b1; ace_crresp = 5'h01;
    step();
    ace_crvalid = 1'b0;
    chk("t7_crready_done", 512'(ace_crready), 512'(0));
    chk("t7_cdready",      512'(ace_cdready), 512'(1));
    wait_rsp("t7");
    pop_check("t7");
    chk("t7_to_cnt",    512'(timeout_count), 512'(1));
    chk("t7_snoop_cnt", 512'(snoop_count),   512'(1));
    finish_rsp();

    chk("sb_empty", 512'(exp_q.size()), 512'(0));
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
